product_ram_reader: RTL and testbench

- Read-side sequencer for the 8-entry product RAM that the multiply datapath fills.
- On a start command it issues sequential reads from a base address for N entries. Addresses wrap modulo 8.
- It absorbs the RAM's 1-cycle synchronous read latency and presents each entry on a valid/ready output stream, tagged with its address and a last flag.
- It accumulates a running sum of the entries read and pulses done at the end.
- Sits between the RAM read port and the result display/host logic.

---
 rtl/product_ram_reader_pkg.sv | 17 +
 rtl/product_ram_reader_if.sv | 29 ++
 rtl/product_ram_reader.sv | 110 +++++++++++
 tb/tb_product_ram_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_ram_reader_pkg.sv
// Shared constants and FSM encoding for the product RAM read sequencer.
package product_ram_reader_pkg;

  localparam int unsigned PramAddrW = 3;
  localparam int unsigned PramDataW = 8;
  localparam int unsigned PramDepth = 1 << PramAddrW;
  localparam int unsigned PramSumW  = 11;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRead    = 3'd1,
    StCapture = 3'd2,
    StHold    = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/product_ram_reader_if.sv
// RAM read port plus the valid/ready entry stream of the product RAM reader.
interface product_ram_reader_if
  import product_ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = PramAddrW,
  parameter int unsigned DATA_W = PramDataW
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  // The reader masters both the RAM read port and the output stream.
  modport master (
    output ram_addr, ram_rd_en, out_data, out_addr, out_valid, out_last,
    input  ram_data, out_ready
  );

  modport slave (
    input  ram_addr, ram_rd_en, out_data, out_addr, out_valid, out_last,
    output ram_data, out_ready
  );

endinterface

// File: rtl/product_ram_reader.sv
// Sequential burst reader for the product RAM: one read outstanding, entries
// presented on a valid/ready stream with address, last flag and running sum.
module product_ram_reader
  import product_ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = PramAddrW,
  parameter int unsigned DATA_W = PramDataW,
  parameter int unsigned SUM_W  = PramSumW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  product_ram_reader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [SUM_W-1:0]    sum
);

  localparam int unsigned     Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MaxCount = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] RemOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start && (count != '0)) begin
          cur_addr_d  = base_addr;
          remaining_d = (count > MaxCount) ? MaxCount : count;
          sum_d       = '0;
          state_d     = StRead;
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
        // RAM data is only meaningful here, one cycle after the read strobe.
        out_data_d  = bus.ram_data;
        out_addr_d  = cur_addr_q;
        out_last_d  = (remaining_q == RemOne);
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          sum_d       = sum_q + SUM_W'(out_data_q);
          remaining_d = remaining_q - RemOne;
          cur_addr_d  = cur_addr_q + AddrOne;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = (remaining_q == RemOne) ? StDone : StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ram_addr  = cur_addr_q;
  assign bus.ram_rd_en = (state_q == StRead);
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign sum           = sum_q;

endmodule

// File: tb/tb_product_ram_reader.sv
// Directed bench for product_ram_reader against a RAM model preloaded with mem[i] = i*3.
module tb_product_ram_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  base_addr = '0;
  logic [3:0]  count = '0;
  logic        busy;
  logic        done;
  logic [10:0] sum;

  int n_cmp = 0;
  int n_fail = 0;

  product_ram_reader_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  product_ram_reader #(.ADDR_W(3), .DATA_W(8), .SUM_W(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model; drives a junk pattern when no read was issued.
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_data <= {5'b0, bus.ram_addr} * 8'd3;
    else               bus.ram_data <= 8'hAA;
  end

  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         acc_n = 0;
  logic [7:0] acc_data [128];
  logic [2:0] acc_addr [128];
  logic       acc_last [128];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.ram_rd_en) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (bus.out_valid && bus.out_ready && acc_n < 128) begin
        acc_data[acc_n] <= bus.out_data;
        acc_addr[acc_n] <= bus.out_addr;
        acc_last[acc_n] <= bus.out_last;
        acc_n <= acc_n + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_burst(input logic [2:0] b, input logic [3:0] c);
    start = 1'b1;
    base_addr = b;
    count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done, sum} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b sum=%0d, required all 0", busy, done, sum);
    end
    n_cmp++;
    if ({bus.ram_rd_en, bus.ram_addr} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_ram: rd_en=%b addr=%0d, required 0", bus.ram_rd_en, bus.ram_addr);
    end
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.out_data, bus.out_addr} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b last=%b data=%0d addr=%0d, required 0",
               bus.out_valid, bus.out_last, bus.out_data, bus.out_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_burst();
    bit ok;
    int r0 = rd_cnt, d0 = done_cnt, a0 = acc_n;
    bus.out_ready = 1'b1;
    start_burst(3'd0, 4'd8);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: busy never dropped"); end
    n_cmp++;
    if (acc_n - a0 != 8) begin
      n_fail++; $display("FAIL full_entries: got %0d, required 8", acc_n - a0);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (acc_addr[a0+i] !== 3'(i) || acc_data[a0+i] !== 8'(i * 3) || acc_last[a0+i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL full_entry%0d: addr=%0d data=%0d last=%b, required addr=%0d data=%0d last=%b",
                 i, acc_addr[a0+i], acc_data[a0+i], acc_last[a0+i], i, i * 3, i == 7);
      end
    end
    n_cmp++;
    if (sum !== 11'd84) begin n_fail++; $display("FAIL full_sum: got %0d, required 84", sum); end
    n_cmp++;
    if (rd_cnt - r0 != 8) begin
      n_fail++; $display("FAIL full_reads: got %0d, required 8", rd_cnt - r0);
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL full_done: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [2:0] ea [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [7:0] ed [4] = '{8'd18, 8'd21, 8'd0, 8'd3};
    int r0 = rd_cnt, a0 = acc_n;
    bus.out_ready = 1'b1;
    start_burst(3'd6, 4'd4);
    wait_idle(ok);
    n_cmp++;
    if (!ok || acc_n - a0 != 4) begin
      n_fail++; $display("FAIL wrap_entries: ok=%b got %0d, required 4", ok, acc_n - a0);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (acc_addr[a0+i] !== ea[i] || acc_data[a0+i] !== ed[i] || acc_last[a0+i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_entry%0d: addr=%0d data=%0d last=%b, required addr=%0d data=%0d last=%b",
                 i, acc_addr[a0+i], acc_data[a0+i], acc_last[a0+i], ea[i], ed[i], i == 3);
      end
    end
    n_cmp++;
    if (sum !== 11'd42) begin n_fail++; $display("FAIL wrap_sum: got %0d, required 42", sum); end
    n_cmp++;
    if (rd_cnt - r0 != 4) begin
      n_fail++; $display("FAIL wrap_reads: got %0d, required 4", rd_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0 = rd_cnt, a0 = acc_n, r1;
    bus.out_ready = 1'b0;
    start_burst(3'd2, 4'd8);
    n_cmp++;
    if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 3'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_read_cycle: rd_en=%b addr=%0d busy=%b, required 1/2/1",
               bus.ram_rd_en, bus.ram_addr, busy);
    end
    tick();
    n_cmp++;
    if (bus.ram_rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_capture_cycle: rd_en=%b valid=%b, required 0/0", bus.ram_rd_en, bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd6 || bus.out_addr !== 3'd2 || bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first_valid: valid=%b data=%0d addr=%0d last=%b, required 1/6/2/0",
               bus.out_valid, bus.out_data, bus.out_addr, bus.out_last);
    end
    r1 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd6 || bus.out_addr !== 3'd2 ||
          bus.ram_rd_en !== 1'b0 || rd_cnt != r1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%0d addr=%0d rd_en=%b reads=%0d, required 1/6/2/0/%0d",
                 i, bus.out_valid, bus.out_data, bus.out_addr, bus.ram_rd_en, rd_cnt, r1);
      end
    end
    bus.out_ready = 1'b1;
    wait_idle(ok);
    n_cmp++;
    if (!ok || acc_n - a0 != 8) begin
      n_fail++; $display("FAIL bp_entries: ok=%b got %0d, required 8", ok, acc_n - a0);
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ea;
      ea = 3'(i + 2);
      n_cmp++;
      if (acc_addr[a0+i] !== ea || acc_data[a0+i] !== {5'b0, ea} * 8'd3) begin
        n_fail++;
        $display("FAIL bp_entry%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, acc_addr[a0+i], acc_data[a0+i], ea, ea * 3);
      end
    end
    n_cmp++;
    if (sum !== 11'd84 || rd_cnt - r0 != 8) begin
      n_fail++;
      $display("FAIL bp_sum_reads: sum=%0d reads=%0d, required 84/8", sum, rd_cnt - r0);
    end
  endtask

  task automatic test_count_edges();
    bit ok;
    int r0 = rd_cnt, d0 = done_cnt, a0;
    bus.out_ready = 1'b1;
    start_burst(3'd3, 4'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || rd_cnt != r0 || done_cnt != d0 || sum !== 11'd84) begin
        n_fail++;
        $display("FAIL count0_cycle%0d: busy=%b reads=%0d dones=%0d sum=%0d, required 0/%0d/%0d/84",
                 i, busy, rd_cnt - r0, done_cnt - d0, sum, 0, 0);
      end
      tick();
    end
    r0 = rd_cnt; d0 = done_cnt; a0 = acc_n;
    start_burst(3'd1, 4'd12);
    wait_idle(ok);
    n_cmp++;
    if (!ok || rd_cnt - r0 != 8 || acc_n - a0 != 8 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL count12: ok=%b reads=%0d entries=%0d dones=%0d, required 1/8/8/1",
               ok, rd_cnt - r0, acc_n - a0, done_cnt - d0);
    end
    n_cmp++;
    if (sum !== 11'd84 || acc_last[a0+7] !== 1'b1 || acc_addr[a0+7] !== 3'd0) begin
      n_fail++;
      $display("FAIL count12_tail: sum=%0d last=%b addr=%0d, required 84/1/0",
               sum, acc_last[a0+7], acc_addr[a0+7]);
    end
  endtask

  task automatic test_start_ignored();
    bit ok = 1'b0;
    logic [2:0] ea [3] = '{3'd4, 3'd5, 3'd6};
    int r0 = rd_cnt, d0 = done_cnt, a0 = acc_n;
    bus.out_ready = 1'b1;
    start_burst(3'd4, 4'd3);
    // Hammer start with a different burst for as long as the reader is busy.
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        start = 1'b0;
        ok = 1'b1;
        break;
      end
      start = 1'b1;
      base_addr = 3'd0;
      count = 4'd8;
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (!ok || acc_n - a0 != 3 || rd_cnt - r0 != 3 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL ign_counts: ok=%b entries=%0d reads=%0d dones=%0d, required 1/3/3/1",
               ok, acc_n - a0, rd_cnt - r0, done_cnt - d0);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (acc_addr[a0+i] !== ea[i] || acc_data[a0+i] !== {5'b0, ea[i]} * 8'd3) begin
        n_fail++;
        $display("FAIL ign_entry%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, acc_addr[a0+i], acc_data[a0+i], ea[i], ea[i] * 3);
      end
    end
    tick();
    tick();
    n_cmp++;
    if (sum !== 11'd45 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_sum: sum=%0d busy=%b, required 45/0", sum, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r0, a0;
    bus.out_ready = 1'b0;
    start_burst(3'd3, 4'd8);
    tick();
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd9) begin
      n_fail++;
      $display("FAIL rstmid_hold: valid=%b data=%0d, required 1/9", bus.out_valid, bus.out_data);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sum, bus.ram_rd_en, bus.ram_addr, bus.out_valid, bus.out_last,
         bus.out_data, bus.out_addr} !== 30'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: busy=%b valid=%b data=%0d addr=%0d ram_addr=%0d, required 0",
               busy, bus.out_valid, bus.out_data, bus.out_addr, bus.ram_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    r0 = rd_cnt; a0 = acc_n;
    bus.out_ready = 1'b1;
    start_burst(3'd5, 4'd2);
    wait_idle(ok);
    n_cmp++;
    if (!ok || acc_n - a0 != 2 || rd_cnt - r0 != 2) begin
      n_fail++;
      $display("FAIL rstmid_counts: ok=%b entries=%0d reads=%0d, required 1/2/2",
               ok, acc_n - a0, rd_cnt - r0);
    end
    n_cmp++;
    if (acc_addr[a0] !== 3'd5 || acc_data[a0] !== 8'd15 || acc_last[a0] !== 1'b0 ||
        acc_addr[a0+1] !== 3'd6 || acc_data[a0+1] !== 8'd18 || acc_last[a0+1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_entries: %0d/%0d/%b %0d/%0d/%b, required 5/15/0 6/18/1",
               acc_addr[a0], acc_data[a0], acc_last[a0],
               acc_addr[a0+1], acc_data[a0+1], acc_last[a0+1]);
    end
    n_cmp++;
    if (sum !== 11'd33) begin n_fail++; $display("FAIL rstmid_sum: got %0d, required 33", sum); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_full_burst();
    test_wrap();
    test_backpressure();
    test_count_edges();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule
